// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: one result buffer per functional unit, round-robin
// grant onto a single registered broadcast bus, with flush and sync reset.
module cdb_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int TAG_W   = 5,
    parameter int DATA_W  = 32
) (
    input  logic                                              clk,
    input  logic                                              reset,
    input  logic                                              flush,
    input  logic [NUM_REQ-1:0]                                in_valid,
    input  logic [NUM_REQ*TAG_W-1:0]                          in_tag,
    input  logic [NUM_REQ*DATA_W-1:0]                         in_data,
    output logic [NUM_REQ-1:0]                                in_ready,
    output logic                                              cdb_valid,
    output logic [TAG_W-1:0]                                  cdb_tag,
    output logic [DATA_W-1:0]                                 cdb_data,
    output logic [((NUM_REQ > 1) ? $clog2(NUM_REQ) : 1)-1:0]  cdb_src
);

    localparam int SRC_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [NUM_REQ-1:0] buf_valid;
    logic [TAG_W-1:0]   buf_tag  [NUM_REQ];
    logic [DATA_W-1:0]  buf_data [NUM_REQ];
    logic [SRC_W-1:0]   rr_ptr;

    logic [NUM_REQ-1:0] grant;
    logic [NUM_REQ-1:0] accept;
    logic               gnt_any;
    logic [SRC_W-1:0]   gnt_idx;
    logic [SRC_W:0]     scan;

    // A buffer may refill on the same edge it drains, so a granted port stays ready.
    assign in_ready = {NUM_REQ{~flush}} & (~buf_valid | grant);
    assign accept   = in_valid & in_ready;

    // Round-robin scan over buffered entries only, starting at rr_ptr.
    always_comb begin
        grant   = '0;
        gnt_any = 1'b0;
        gnt_idx = '0;
        scan    = '0;
        if (!flush) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                scan = {1'b0, rr_ptr} + (SRC_W+1)'(k);
                if (scan >= (SRC_W+1)'(NUM_REQ)) begin
                    scan = scan - (SRC_W+1)'(NUM_REQ);
                end
                if (!gnt_any && buf_valid[scan[SRC_W-1:0]]) begin
                    gnt_any = 1'b1;
                    gnt_idx = scan[SRC_W-1:0];
                end
            end
        end
        grant[gnt_idx] = gnt_any;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            buf_valid <= '0;
            rr_ptr    <= '0;
            cdb_valid <= 1'b0;
            cdb_tag   <= '0;
            cdb_data  <= '0;
            cdb_src   <= '0;
        end else if (flush) begin
            buf_valid <= '0;
            cdb_valid <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (accept[i]) begin
                    buf_valid[i] <= 1'b1;
                end else if (grant[i]) begin
                    buf_valid[i] <= 1'b0;
                end
            end
            cdb_valid <= gnt_any;
            if (gnt_any) begin
                cdb_tag  <= buf_tag[gnt_idx];
                cdb_data <= buf_data[gnt_idx];
                cdb_src  <= gnt_idx;
                rr_ptr   <= (int'(gnt_idx) == NUM_REQ - 1) ? '0 : gnt_idx + 1'b1;
            end
        end
    end

    // Payload storage carries no reset; buf_valid alone qualifies it.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_REQ; i++) begin
            if (accept[i]) begin
                buf_tag[i]  <= in_tag[i*TAG_W +: TAG_W];
                buf_data[i] <= in_data[i*DATA_W +: DATA_W];
            end
        end
    end

endmodule
